// File: rtl/pipe_controller.sv
// Control unit for the 5-stage MIPS pipeline: D-stage decode, E/M/W control registers, hazard unit.
// Latency: decode and hazard outputs are combinational in D; control bits reach E/M/W after 1/2/3 cycles.
// Backpressure: stallF/stallD hold the front end while flushE inserts a bubble; a stall suppresses flushD.
module pipe_controller #(
    parameter int REGW       = 5,
    parameter int ALUCW      = 3,
    parameter int EXT_OPS    = 1,
    parameter int ENABLE_FWD = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opD,
    input  logic [5:0]       functD,
    input  logic [REGW-1:0]  rsD,
    input  logic [REGW-1:0]  rtD,
    input  logic             equalD,
    input  logic [REGW-1:0]  rsE,
    input  logic [REGW-1:0]  rtE,
    input  logic [REGW-1:0]  writeregE,
    input  logic [REGW-1:0]  writeregM,
    input  logic [REGW-1:0]  writeregW,
    output logic             pcsrcD,
    output logic             jumpD,
    output logic             illegalD,
    output logic             regdstE,
    output logic             alusrcE,
    output logic             immzextE,
    output logic [ALUCW-1:0] alucontrolE,
    output logic             regwriteE,
    output logic             regwriteM,
    output logic             regwriteW,
    output logic             memtoregE,
    output logic             memtoregM,
    output logic             memtoregW,
    output logic             memwriteM,
    output logic             forwardAD,
    output logic             forwardBD,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             stallF,
    output logic             stallD,
    output logic             flushE,
    output logic             flushD
);

    // Opcodes and R-type functs
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU codes, zero-extended to the configured control width
    localparam logic [ALUCW-1:0] ALU_AND = ALUCW'(3'b000);
    localparam logic [ALUCW-1:0] ALU_OR  = ALUCW'(3'b001);
    localparam logic [ALUCW-1:0] ALU_ADD = ALUCW'(3'b010);
    localparam logic [ALUCW-1:0] ALU_SUB = ALUCW'(3'b110);
    localparam logic [ALUCW-1:0] ALU_SLT = ALUCW'(3'b111);

    localparam logic [REGW-1:0] REG_ZERO = '0;

    // Control bits carried into E; M and W keep only the subset they consume
    typedef struct packed {
        logic             regwrite;
        logic             memtoreg;
        logic             memwrite;
        logic             alusrc;
        logic             regdst;
        logic             immzext;
        logic [ALUCW-1:0] alucontrol;
    } ctrl_e_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
        logic memwrite;
    } ctrl_m_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
    } ctrl_w_t;

    ctrl_e_t ctrl_dec;
    logic    branch_dec;
    logic    bne_dec;
    logic    jump_dec;
    logic    illegal_dec;

    ctrl_e_t ctrl_e_d, ctrl_e_q;
    ctrl_m_t ctrl_m_d, ctrl_m_q;
    ctrl_w_t ctrl_w_d, ctrl_w_q;

    logic stall;
    logic lwstall;
    logic branchstall;

    // Register-number match that never fires on $0
    function automatic logic reg_hit(input logic [REGW-1:0] a, input logic [REGW-1:0] b);
        return (a != REG_ZERO) && (a == b);
    endfunction

    // Instruction decode for the D stage; anything unrecognised decodes to all-zero controls
    always_comb begin
        ctrl_dec    = '0;
        branch_dec  = 1'b0;
        bne_dec     = 1'b0;
        jump_dec    = 1'b0;
        illegal_dec = 1'b0;
        unique case (opD)
            OP_RTYPE: begin
                ctrl_dec.regwrite = 1'b1;
                ctrl_dec.regdst   = 1'b1;
                case (functD)
                    FN_ADD:  ctrl_dec.alucontrol = ALU_ADD;
                    FN_SUB:  ctrl_dec.alucontrol = ALU_SUB;
                    FN_AND:  ctrl_dec.alucontrol = ALU_AND;
                    FN_OR:   ctrl_dec.alucontrol = ALU_OR;
                    FN_SLT:  ctrl_dec.alucontrol = ALU_SLT;
                    default: illegal_dec = 1'b1;
                endcase
            end
            OP_LW: begin
                ctrl_dec.regwrite   = 1'b1;
                ctrl_dec.alusrc     = 1'b1;
                ctrl_dec.memtoreg   = 1'b1;
                ctrl_dec.alucontrol = ALU_ADD;
            end
            OP_SW: begin
                ctrl_dec.memwrite   = 1'b1;
                ctrl_dec.alusrc     = 1'b1;
                ctrl_dec.alucontrol = ALU_ADD;
            end
            OP_BEQ: begin
                branch_dec          = 1'b1;
                ctrl_dec.alucontrol = ALU_SUB;
            end
            OP_J: begin
                jump_dec = 1'b1;
            end
            OP_BNE: begin
                if (EXT_OPS != 0) begin
                    branch_dec          = 1'b1;
                    bne_dec             = 1'b1;
                    ctrl_dec.alucontrol = ALU_SUB;
                end else begin
                    illegal_dec = 1'b1;
                end
            end
            OP_ADDI: begin
                if (EXT_OPS != 0) begin
                    ctrl_dec.regwrite   = 1'b1;
                    ctrl_dec.alusrc     = 1'b1;
                    ctrl_dec.alucontrol = ALU_ADD;
                end else begin
                    illegal_dec = 1'b1;
                end
            end
            OP_ANDI: begin
                if (EXT_OPS != 0) begin
                    ctrl_dec.regwrite   = 1'b1;
                    ctrl_dec.alusrc     = 1'b1;
                    ctrl_dec.immzext    = 1'b1;
                    ctrl_dec.alucontrol = ALU_AND;
                end else begin
                    illegal_dec = 1'b1;
                end
            end
            OP_ORI: begin
                if (EXT_OPS != 0) begin
                    ctrl_dec.regwrite   = 1'b1;
                    ctrl_dec.alusrc     = 1'b1;
                    ctrl_dec.immzext    = 1'b1;
                    ctrl_dec.alucontrol = ALU_OR;
                end else begin
                    illegal_dec = 1'b1;
                end
            end
            OP_SLTI: begin
                if (EXT_OPS != 0) begin
                    ctrl_dec.regwrite   = 1'b1;
                    ctrl_dec.alusrc     = 1'b1;
                    ctrl_dec.alucontrol = ALU_SLT;
                end else begin
                    illegal_dec = 1'b1;
                end
            end
            default: illegal_dec = 1'b1;
        endcase
        // An illegal instruction must not leave any partial control behind
        if (illegal_dec) begin
            ctrl_dec   = '0;
            branch_dec = 1'b0;
            bne_dec    = 1'b0;
            jump_dec   = 1'b0;
        end
    end

    // Hazard detection: forwarding selects plus the stall needed in the configured mode
    always_comb begin
        forwardAE   = 2'b00;
        forwardBE   = 2'b00;
        forwardAD   = 1'b0;
        forwardBD   = 1'b0;
        lwstall     = 1'b0;
        branchstall = 1'b0;
        stall       = 1'b0;
        if (ENABLE_FWD != 0) begin
            // M holds the younger result, so it takes priority over W
            if (reg_hit(rsE, writeregM) && ctrl_m_q.regwrite) begin
                forwardAE = 2'b10;
            end else if (reg_hit(rsE, writeregW) && ctrl_w_q.regwrite) begin
                forwardAE = 2'b01;
            end
            if (reg_hit(rtE, writeregM) && ctrl_m_q.regwrite) begin
                forwardBE = 2'b10;
            end else if (reg_hit(rtE, writeregW) && ctrl_w_q.regwrite) begin
                forwardBE = 2'b01;
            end
            forwardAD = reg_hit(rsD, writeregM) && ctrl_m_q.regwrite;
            forwardBD = reg_hit(rtD, writeregM) && ctrl_m_q.regwrite;
            // Load data is not available until the end of M
            lwstall = ctrl_e_q.memtoreg && (reg_hit(rtE, rsD) || reg_hit(rtE, rtD));
            // The D comparator can only take ALUoutM, so E results and M loads must wait
            branchstall = branch_dec &&
                ((ctrl_e_q.regwrite && (reg_hit(writeregE, rsD) || reg_hit(writeregE, rtD))) ||
                 (ctrl_m_q.memtoreg && (reg_hit(writeregM, rsD) || reg_hit(writeregM, rtD))));
            stall = lwstall || branchstall;
        end else begin
            // W needs no check: the register file writes in the first half-cycle
            stall = (ctrl_e_q.regwrite && (reg_hit(rsD, writeregE) || reg_hit(rtD, writeregE))) ||
                    (ctrl_m_q.regwrite && (reg_hit(rsD, writeregM) || reg_hit(rtD, writeregM)));
        end
    end

    // Front-end control: a stall holds D, so a taken branch waits until the stall clears
    always_comb begin
        illegalD = illegal_dec;
        jumpD    = jump_dec;
        pcsrcD   = (branch_dec && !bne_dec && equalD) || (bne_dec && !equalD);
        stallF   = stall;
        stallD   = stall;
        flushE   = stall;
        flushD   = (pcsrcD || jumpD) && !stall;
    end

    // Next state of the pipeline control registers; flushE inserts a bubble into E
    always_comb begin
        ctrl_e_d = flushE ? '0 : ctrl_dec;
        ctrl_m_d = '{regwrite: ctrl_e_q.regwrite,
                     memtoreg: ctrl_e_q.memtoreg,
                     memwrite: ctrl_e_q.memwrite};
        ctrl_w_d = '{regwrite: ctrl_m_q.regwrite,
                     memtoreg: ctrl_m_q.memtoreg};
    end

    // Pipeline control registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_e_q <= '0;
            ctrl_m_q <= '0;
            ctrl_w_q <= '0;
        end else begin
            ctrl_e_q <= ctrl_e_d;
            ctrl_m_q <= ctrl_m_d;
            ctrl_w_q <= ctrl_w_d;
        end
    end

    // Stage outputs
    always_comb begin
        regdstE     = ctrl_e_q.regdst;
        alusrcE     = ctrl_e_q.alusrc;
        immzextE    = ctrl_e_q.immzext;
        alucontrolE = ctrl_e_q.alucontrol;
        regwriteE   = ctrl_e_q.regwrite;
        memtoregE   = ctrl_e_q.memtoreg;
        regwriteM   = ctrl_m_q.regwrite;
        memtoregM   = ctrl_m_q.memtoreg;
        memwriteM   = ctrl_m_q.memwrite;
        regwriteW   = ctrl_w_q.regwrite;
        memtoregW   = ctrl_w_q.memtoreg;
    end

endmodule

// File: tb/tb_pipe_controller.sv
// Directed bench for pipe_controller: default build (forwarding, extended ops) plus a stall-only, base-ISA build.
// Latency: bench shifts rs/rt/writereg fields one stage per clock, mirroring the datapath around the controller.
// Backpressure: the bench holds D and injects an E bubble on cycles where it expects a stall.
module tb_pipe_controller;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_BAD   = 6'b111111;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opD, functD;
    logic [4:0] rsD, rtD, rdD;
    logic       equalD;
    logic [4:0] rsE, rtE, writeregE, writeregM, writeregW;

    // Default build outputs
    logic       pcsrcD, jumpD, illegalD, regdstE, alusrcE, immzextE;
    logic [2:0] alucontrolE;
    logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, memtoregW, memwriteM;
    logic       forwardAD, forwardBD;
    logic [1:0] forwardAE, forwardBE;
    logic       stallF, stallD, flushE, flushD;

    // Stall-only, base-ISA build outputs
    logic       pcsrcD_b, jumpD_b, illegalD_b, regdstE_b, alusrcE_b, immzextE_b;
    logic [2:0] alucontrolE_b;
    logic       regwriteE_b, regwriteM_b, regwriteW_b, memtoregE_b, memtoregM_b, memtoregW_b, memwriteM_b;
    logic       forwardAD_b, forwardBD_b;
    logic [1:0] forwardAE_b, forwardBE_b;
    logic       stallF_b, stallD_b, flushE_b, flushD_b;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    pipe_controller u0 (
        .clk(clk), .reset(reset), .opD(opD), .functD(functD), .rsD(rsD), .rtD(rtD), .equalD(equalD),
        .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .pcsrcD(pcsrcD), .jumpD(jumpD), .illegalD(illegalD), .regdstE(regdstE), .alusrcE(alusrcE),
        .immzextE(immzextE), .alucontrolE(alucontrolE), .regwriteE(regwriteE), .regwriteM(regwriteM),
        .regwriteW(regwriteW), .memtoregE(memtoregE), .memtoregM(memtoregM), .memtoregW(memtoregW),
        .memwriteM(memwriteM), .forwardAD(forwardAD), .forwardBD(forwardBD), .forwardAE(forwardAE),
        .forwardBE(forwardBE), .stallF(stallF), .stallD(stallD), .flushE(flushE), .flushD(flushD)
    );

    pipe_controller #(.EXT_OPS(0), .ENABLE_FWD(0)) u1 (
        .clk(clk), .reset(reset), .opD(opD), .functD(functD), .rsD(rsD), .rtD(rtD), .equalD(equalD),
        .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .pcsrcD(pcsrcD_b), .jumpD(jumpD_b), .illegalD(illegalD_b), .regdstE(regdstE_b), .alusrcE(alusrcE_b),
        .immzextE(immzextE_b), .alucontrolE(alucontrolE_b), .regwriteE(regwriteE_b), .regwriteM(regwriteM_b),
        .regwriteW(regwriteW_b), .memtoregE(memtoregE_b), .memtoregM(memtoregM_b), .memtoregW(memtoregW_b),
        .memwriteM(memwriteM_b), .forwardAD(forwardAD_b), .forwardBD(forwardBD_b), .forwardAE(forwardAE_b),
        .forwardBE(forwardBE_b), .stallF(stallF_b), .stallD(stallD_b), .flushE(flushE_b), .flushD(flushD_b)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        opD = op; functD = fn; rsD = rs; rtD = rt; rdD = rd;
    endtask

    task automatic clear_fields();
        rsE = '0; rtE = '0; writeregE = '0; writeregM = '0; writeregW = '0;
    endtask

    // One clock: shift datapath register fields; bubble models an expected flushE
    task automatic adv(input logic bubble);
        @(posedge clk);
        #1;
        writeregW = writeregM;
        writeregM = writeregE;
        if (bubble) begin
            rsE = '0; rtE = '0; writeregE = '0;
        end else begin
            rsE = rsD; rtE = rtD;
            writeregE = (opD == OP_R) ? rdD : rtD;
        end
        #1;
    endtask

    function automatic logic [7:0] emw0();
        return {1'b0, regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, memtoregW, memwriteM};
    endfunction

    initial begin
        reset = 1'b0;
        equalD = 1'b0;
        clear_fields();
        issue(OP_LW, 6'd0, 5'd2, 5'd1, 5'd0);
        #1;
        chk("reset_emw", emw0(), 8'h00);
        adv(1'b1);
        adv(1'b1);
        reset = 1'b1;
        #1;
        chk("post_release_emw", emw0(), 8'h00);
        chk("post_release_stall", {5'd0, stallF, stallD, flushE}, 8'h00);

        // lw reaches E one cycle after D
        adv(1'b0);
        chk("lw_e_ctrl", {3'd0, regwriteE, memtoregE, alusrcE, regdstE, immzextE}, 8'b0001_1100);
        chk("lw_e_alu", {5'd0, alucontrolE}, 8'h02);
        issue(OP_R, F_AND, 5'd1, 5'd5, 5'd4);
        #1;
        chk("lwuse_stall", {5'd0, stallF, stallD, flushE}, 8'h07);
        chk("lwuse_flushD", {7'd0, flushD}, 8'h00);

        // Reset mid-stream with lw in E
        reset = 1'b0;
        #1;
        chk("midreset_emw", emw0(), 8'h00);
        chk("midreset_stall", {5'd0, stallF, stallD, flushE}, 8'h00);
        @(posedge clk);
        #1;
        clear_fields();
        reset = 1'b1;
        adv(1'b0);
        chk("after_release_stall", {5'd0, stallF, stallD, flushE}, 8'h00);
        chk("after_release_fwd", {4'd0, forwardAE, forwardBE}, 8'h00);

        // add $1 directly ahead of sub: forward from M
        issue(OP_R, F_ADD, 5'd2, 5'd3, 5'd1);
        adv(1'b0);
        issue(OP_R, F_SUB, 5'd1, 5'd3, 5'd2);
        #1;
        chk("sub_d_stall", {7'd0, stallD}, 8'h00);
        adv(1'b0);
        chk("fwdAE_M", {6'd0, forwardAE}, 8'h02);
        chk("fwdBE_none", {6'd0, forwardBE}, 8'h00);
        chk("sub_alu", {5'd0, alucontrolE}, 8'h06);
        // add $1 two ahead: forward from W
        issue(OP_R, F_OR, 5'd1, 5'd7, 5'd5);
        adv(1'b0);
        chk("fwdAE_W", {6'd0, forwardAE}, 8'h01);
        chk("or_alu", {5'd0, alucontrolE}, 8'h01);
        chk("or_stall", {7'd0, stallD}, 8'h00);

        // lw $1 then and $4,$1,$5: one stall cycle then W forward
        issue(OP_LW, 6'd0, 5'd2, 5'd1, 5'd0);
        adv(1'b0);
        issue(OP_R, F_AND, 5'd1, 5'd5, 5'd4);
        #1;
        chk("lw2_stall", {5'd0, stallF, stallD, flushE}, 8'h07);
        adv(1'b1);
        chk("lw2_stall_clear", {5'd0, stallF, stallD, flushE}, 8'h00);
        chk("lw2_bubble_E", {6'd0, regwriteE, memtoregM}, 8'h01);
        adv(1'b0);
        chk("lw2_fwdAE", {6'd0, forwardAE}, 8'h01);
        chk("lw2_fwdBE", {6'd0, forwardBE}, 8'h00);
        chk("lw2_memtoregW", {7'd0, memtoregW}, 8'h01);
        // lw writing $0 never stalls
        issue(OP_LW, 6'd0, 5'd2, 5'd0, 5'd0);
        adv(1'b0);
        issue(OP_R, F_ADD, 5'd0, 5'd0, 5'd3);
        #1;
        chk("lw0_nostall", {5'd0, stallF, stallD, flushE}, 8'h00);

        // add $1; beq $1,$2: branch stall, then forwardAD
        issue(OP_R, F_ADD, 5'd2, 5'd3, 5'd1);
        adv(1'b0);
        issue(OP_BEQ, 6'd0, 5'd1, 5'd2, 5'd0);
        #1;
        chk("beq_stall", {5'd0, stallF, stallD, flushE}, 8'h07);
        equalD = 1'b1;
        #1;
        chk("beq_stall_wins", {6'd0, pcsrcD, flushD}, 8'h02);
        adv(1'b1);
        chk("beq_stall_clear", {5'd0, stallF, stallD, flushE}, 8'h00);
        chk("beq_fwdD", {6'd0, forwardAD, forwardBD}, 8'h02);
        chk("beq_taken", {6'd0, pcsrcD, flushD}, 8'h03);

        // Extended opcodes
        equalD = 1'b0;
        issue(OP_ORI, 6'd0, 5'd6, 5'd5, 5'd0);
        #1;
        chk("ori_legal", {6'd0, illegalD, illegalD_b}, 8'h01);
        adv(1'b0);
        chk("ori_e_ctrl", {3'd0, regwriteE, memtoregE, alusrcE, regdstE, immzextE}, 8'b0001_0101);
        chk("ori_alu", {5'd0, alucontrolE}, 8'h01);
        chk("ori_base_e", {3'd0, regwriteE_b, alusrcE_b, immzextE_b, regdstE_b, memtoregE_b}, 8'h00);
        chk("ori_base_alu", {5'd0, alucontrolE_b}, 8'h00);
        issue(OP_BNE, 6'd0, 5'd7, 5'd8, 5'd0);
        #1;
        chk("bne_taken", {6'd0, pcsrcD, flushD}, 8'h03);
        chk("bne_base", {6'd0, illegalD_b, pcsrcD_b}, 8'h02);
        equalD = 1'b1;
        #1;
        chk("bne_not_taken", {6'd0, pcsrcD, flushD}, 8'h00);
        equalD = 1'b0;
        issue(OP_J, 6'd0, 5'd0, 5'd0, 5'd0);
        #1;
        chk("jump", {5'd0, jumpD, pcsrcD, flushD}, 8'h05);

        // Stall-only build: add $1; add $2,$1,$1 stalls twice
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_fields();
        #2;
        reset = 1'b1;
        issue(OP_R, F_ADD, 5'd2, 5'd3, 5'd1);
        #1;
        chk("sonly_idle", {7'd0, stallD_b}, 8'h00);
        adv(1'b0);
        issue(OP_R, F_ADD, 5'd1, 5'd1, 5'd2);
        #1;
        chk("sonly_stall1", {5'd0, stallF_b, stallD_b, flushE_b}, 8'h07);
        chk("sonly_fwd1", {2'd0, forwardAE_b, forwardBE_b, forwardAD_b, forwardBD_b}, 8'h00);
        adv(1'b1);
        chk("sonly_stall2", {5'd0, stallF_b, stallD_b, flushE_b}, 8'h07);
        chk("sonly_fwd2", {2'd0, forwardAE_b, forwardBE_b, forwardAD_b, forwardBD_b}, 8'h00);
        adv(1'b1);
        chk("sonly_w_nostall", {5'd0, stallF_b, stallD_b, flushE_b}, 8'h00);
        adv(1'b0);
        chk("sonly_add2_e", {4'd0, regwriteE_b, alucontrolE_b}, 8'h0A);
        chk("sonly_fwd3", {4'd0, forwardAE_b, forwardBE_b}, 8'h00);

        // Unknown R-type funct
        issue(OP_R, F_BAD, 5'd9, 5'd10, 5'd11);
        #1;
        chk("badfn_illegal", {6'd0, illegalD, illegalD_b}, 8'h03);
        adv(1'b0);
        chk("badfn_e", {6'd0, regwriteE_b, regdstE_b}, 8'h00);
        chk("badfn_e_fwd_build", {6'd0, regwriteE, regdstE}, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
